// File: rtl/fwd_writeback_pipe_if.sv
// Bus bundle between the execution-unit result pipes and the forwarding/writeback block.
// Packet layout: [127:0] data, [130:128] lat, [131] wr_en, [138:132] rt.
interface fwd_writeback_pipe_if;
  logic         flush;
  logic [138:0] in_pkt0;
  logic [138:0] in_pkt1;
  logic [6:0]   q_addr_a;
  logic [6:0]   q_addr_b;
  logic [6:0]   q_addr_c;
  logic [2:0]   fwd_hit;
  logic [127:0] fwd_data_a;
  logic [127:0] fwd_data_b;
  logic [127:0] fwd_data_c;
  logic         rf_we0;
  logic         rf_we1;
  logic [6:0]   rf_addr0;
  logic [6:0]   rf_addr1;
  logic [127:0] rf_data0;
  logic [127:0] rf_data1;
  logic         err_lat;
  logic         err_collision;
  logic         wb_conflict;

  modport master (
    output flush, in_pkt0, in_pkt1, q_addr_a, q_addr_b, q_addr_c,
    input  fwd_hit, fwd_data_a, fwd_data_b, fwd_data_c,
    input  rf_we0, rf_we1, rf_addr0, rf_addr1, rf_data0, rf_data1,
    input  err_lat, err_collision, wb_conflict
  );

  modport slave (
    input  flush, in_pkt0, in_pkt1, q_addr_a, q_addr_b, q_addr_c,
    output fwd_hit, fwd_data_a, fwd_data_b, fwd_data_c,
    output rf_we0, rf_we1, rf_addr0, rf_addr1, rf_data0, rf_data1,
    output err_lat, err_collision, wb_conflict
  );
endinterface

// File: rtl/fwd_writeback_pipe.sv
// Ages per-pipe result packets in a shift chain to a common writeback depth and
// serves youngest-first operand forwarding from every in-flight slot.
module fwd_writeback_pipe #(
  parameter int DEPTH       = 7,
  parameter int FLUSH_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  fwd_writeback_pipe_if.slave bus
);
  localparam int NP = 2;

  logic         r_v      [NP][1:DEPTH];
  logic [6:0]   r_rt     [NP][1:DEPTH];
  logic [127:0] r_data   [NP][1:DEPTH];
  logic         r_wb_v   [NP];
  logic [6:0]   r_wb_rt  [NP];
  logic [127:0] r_wb_data[NP];
  logic         r_err_lat;
  logic         r_err_coll;
  logic         r_wb_conf;

  logic         w_v      [NP][1:DEPTH];
  logic [6:0]   w_rt     [NP][1:DEPTH];
  logic [127:0] w_data   [NP][1:DEPTH];
  logic         w_err_lat;
  logic         w_err_coll;
  logic         w_conf;
  logic [138:0] w_pkt    [NP];
  logic [2:0]   w_lat    [NP];
  logic [6:0]   w_q      [3];

  assign w_pkt[0] = bus.in_pkt0;
  assign w_pkt[1] = bus.in_pkt1;
  assign w_lat[0] = bus.in_pkt0[130:128];
  assign w_lat[1] = bus.in_pkt1[130:128];
  assign w_q[0]   = bus.q_addr_a;
  assign w_q[1]   = bus.q_addr_b;
  assign w_q[2]   = bus.q_addr_c;

  assign w_conf = r_v[0][DEPTH] && r_v[1][DEPTH] && (r_rt[0][DEPTH] == r_rt[1][DEPTH]);

  // Shift by one slot, masking speculative entries on flush, then overlay insertions.
  always_comb begin
    w_err_lat  = 1'b0;
    w_err_coll = 1'b0;
    for (int p = 0; p < NP; p++) begin
      w_v[p][1]    = 1'b0;
      w_rt[p][1]   = '0;
      w_data[p][1] = '0;
      for (int s = 2; s <= DEPTH; s++) begin
        w_v[p][s]    = r_v[p][s-1] && !(bus.flush && ((s - 1) < FLUSH_DEPTH));
        w_rt[p][s]   = r_rt[p][s-1];
        w_data[p][s] = r_data[p][s-1];
      end
      if (w_pkt[p][131]) begin
        if ((w_lat[p] == 3'd0) || (int'(w_lat[p]) > DEPTH)) begin
          w_err_lat = 1'b1;
        end else if (!bus.flush) begin
          for (int s = 1; s <= DEPTH; s++) begin
            if (int'(w_lat[p]) == s) begin
              w_err_coll   = w_err_coll | w_v[p][s];
              w_v[p][s]    = 1'b1;
              w_rt[p][s]   = w_pkt[p][138:132];
              w_data[p][s] = w_pkt[p][127:0];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NP; p++) begin
        for (int s = 1; s <= DEPTH; s++) begin
          r_v[p][s]    <= 1'b0;
          r_rt[p][s]   <= '0;
          r_data[p][s] <= '0;
        end
        r_wb_v[p]    <= 1'b0;
        r_wb_rt[p]   <= '0;
        r_wb_data[p] <= '0;
      end
      r_err_lat  <= 1'b0;
      r_err_coll <= 1'b0;
      r_wb_conf  <= 1'b0;
    end else begin
      r_v          <= w_v;
      r_rt         <= w_rt;
      r_data       <= w_data;
      r_wb_v[0]    <= r_v[0][DEPTH];
      r_wb_v[1]    <= r_v[1][DEPTH] && !w_conf;
      r_wb_rt[0]   <= r_rt[0][DEPTH];
      r_wb_rt[1]   <= r_rt[1][DEPTH];
      r_wb_data[0] <= r_data[0][DEPTH];
      r_wb_data[1] <= r_data[1][DEPTH];
      r_err_lat    <= w_err_lat;
      r_err_coll   <= w_err_coll;
      r_wb_conf    <= w_conf;
    end
  end

  // Walk from oldest to youngest so the youngest (and pipe0 at equal age) overrides.
  for (genvar gi = 0; gi < 3; gi++) begin : g_fwd
    logic         w_hit;
    logic [127:0] w_fdata;
    always_comb begin
      w_hit   = 1'b0;
      w_fdata = '0;
      for (int p = NP - 1; p >= 0; p--) begin
        if (r_wb_v[p] && (r_wb_rt[p] == w_q[gi])) begin
          w_hit   = 1'b1;
          w_fdata = r_wb_data[p];
        end
      end
      for (int s = DEPTH; s >= 1; s--) begin
        for (int p = NP - 1; p >= 0; p--) begin
          if (r_v[p][s] && (r_rt[p][s] == w_q[gi])) begin
            w_hit   = 1'b1;
            w_fdata = r_data[p][s];
          end
        end
      end
    end
  end

  assign bus.fwd_hit       = {g_fwd[2].w_hit, g_fwd[1].w_hit, g_fwd[0].w_hit};
  assign bus.fwd_data_a    = g_fwd[0].w_fdata;
  assign bus.fwd_data_b    = g_fwd[1].w_fdata;
  assign bus.fwd_data_c    = g_fwd[2].w_fdata;
  assign bus.rf_we0        = r_wb_v[0];
  assign bus.rf_we1        = r_wb_v[1];
  assign bus.rf_addr0      = r_wb_rt[0];
  assign bus.rf_addr1      = r_wb_rt[1];
  assign bus.rf_data0      = r_wb_data[0];
  assign bus.rf_data1      = r_wb_data[1];
  assign bus.err_lat       = r_err_lat;
  assign bus.err_collision = r_err_coll;
  assign bus.wb_conflict   = r_wb_conf;
endmodule

// File: tb/tb_fwd_writeback_pipe.sv
// Bench for fwd_writeback_pipe: latency table, directed corner sequences and a
// randomized run checked against an aged-packet list model.
module tb_fwd_writeback_pipe;
  localparam int DEPTH = 7;
  localparam int FD    = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  fwd_writeback_pipe_if bus();
  fwd_writeback_pipe #(.DEPTH(DEPTH), .FLUSH_DEPTH(FD)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Writeback/pulse monitor sampled on the falling edge.
  int           wb_cnt [128] = '{default: 0};
  int           wb_cyc [128] = '{default: 0};
  logic [127:0] wb_dat [128];
  int           elat_cnt = 0, ecoll_cnt = 0, conf_cnt = 0, conf_cyc = 0;
  logic         conf_we0 = 1'b0, conf_we1 = 1'b0;
  logic [6:0]   conf_addr0 = '0;
  always @(negedge clk) begin
    if (bus.rf_we0) begin
      wb_cnt[bus.rf_addr0] <= wb_cnt[bus.rf_addr0] + 1;
      wb_cyc[bus.rf_addr0] <= cyc;
      wb_dat[bus.rf_addr0] <= bus.rf_data0;
    end
    if (bus.rf_we1) begin
      wb_cnt[bus.rf_addr1] <= wb_cnt[bus.rf_addr1] + 1;
      wb_cyc[bus.rf_addr1] <= cyc;
      wb_dat[bus.rf_addr1] <= bus.rf_data1;
    end
    if (bus.err_lat)       elat_cnt  <= elat_cnt + 1;
    if (bus.err_collision) ecoll_cnt <= ecoll_cnt + 1;
    if (bus.wb_conflict) begin
      conf_cnt   <= conf_cnt + 1;
      conf_cyc   <= cyc;
      conf_we0   <= bus.rf_we0;
      conf_we1   <= bus.rf_we1;
      conf_addr0 <= bus.rf_addr0;
    end
  end

  typedef struct {
    bit         we;
    bit         pipe;
    logic [2:0] lat;
    logic [6:0] rt;
    int         exp_wb;
    int         exp_delay;
    bit         exp_err;
  } vec_t;

  typedef struct {
    bit           p;
    logic [6:0]   rt;
    logic [127:0] d;
    int           age;
  } ent_t;
  ent_t mq[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_pkt0 = '0;
    bus.in_pkt1 = '0;
    bus.flush   = 1'b0;
  endtask

  function automatic logic [138:0] mk(input logic [2:0] lat, input logic [6:0] rt, input logic [127:0] d);
    return {rt, 1'b1, lat, d};
  endfunction

  function automatic logic [127:0] dat_of(input logic [6:0] rt);
    return {16{1'b0, rt}};
  endfunction

  // Model: list of in-flight packets tagged with their age; age DEPTH+1 is the writeback stage.
  task automatic model_step(input logic [138:0] pk0, input logic [138:0] pk1, input bit fl,
                            output bit e_lat, output bit e_coll);
    ent_t nq[$];
    ent_t e;
    logic [138:0] pk;
    int L;
    e_lat  = 1'b0;
    e_coll = 1'b0;
    foreach (mq[i]) begin
      e = mq[i];
      if (!(fl && e.age < FD)) begin
        e.age = e.age + 1;
        if (e.age <= DEPTH + 1) nq.push_back(e);
      end
    end
    for (int p = 0; p < 2; p++) begin
      pk = (p == 1) ? pk1 : pk0;
      L  = int'(pk[130:128]);
      if (pk[131]) begin
        if (L == 0 || L > DEPTH) e_lat = 1'b1;
        else if (!fl) begin
          for (int i = nq.size() - 1; i >= 0; i--) begin
            if (int'(nq[i].p) == p && nq[i].age == L) begin
              nq.delete(i);
              e_coll = 1'b1;
            end
          end
          e.p = (p == 1); e.rt = pk[138:132]; e.d = pk[127:0]; e.age = L;
          nq.push_back(e);
        end
      end
    end
    mq = nq;
  endtask

  function automatic logic [128:0] model_fwd(input logic [6:0] q);
    int best = -1;
    foreach (mq[i]) begin
      if (mq[i].rt == q) begin
        if (best < 0 || mq[i].age < mq[best].age ||
            (mq[i].age == mq[best].age && mq[i].p < mq[best].p)) best = i;
      end
    end
    return (best < 0) ? 129'd0 : {1'b1, mq[best].d};
  endfunction

  initial begin
    vec_t tbl[9];
    int ins, b0, b1, b2, be;
    logic [127:0] da, db;
    logic [138:0] p0, p1;
    bit fl, el, ec, w0, w1, cf;
    logic [6:0] a0, a1;
    logic [127:0] d0, d1;

    tbl[0] = '{1'b1, 1'b0, 3'd1, 7'd50, 1, 7, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 3'd2, 7'd51, 1, 6, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 3'd3, 7'd52, 1, 5, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 3'd4, 7'd53, 1, 4, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 3'd5, 7'd54, 1, 3, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 3'd6, 7'd55, 1, 2, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 3'd7, 7'd56, 1, 1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 3'd0, 7'd57, 0, 0, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 3'd3, 7'd58, 0, 0, 1'b0};

    idle();
    bus.q_addr_a = 7'd5; bus.q_addr_b = 7'd9; bus.q_addr_c = 7'd0;
    tick(); tick();
    chk("reset_rf_we", {bus.rf_we0, bus.rf_we1}, 0);
    chk("reset_flags", {bus.err_lat, bus.err_collision, bus.wb_conflict}, 0);
    chk("reset_fwd", {bus.fwd_hit, bus.fwd_data_a}, 0);
    reset = 1'b1;
    tick();

    // Latency table: one packet per vector, then drain.
    for (int i = 0; i < 9; i++) begin
      b0 = wb_cnt[tbl[i].rt];
      p0 = {tbl[i].rt, tbl[i].we, tbl[i].lat, dat_of(tbl[i].rt)};
      if (tbl[i].pipe) bus.in_pkt1 = p0; else bus.in_pkt0 = p0;
      tick(); ins = cyc; idle();
      chk("tbl_err_lat", bus.err_lat, tbl[i].exp_err);
      repeat (10) tick();
      chk("tbl_wb_cnt", wb_cnt[tbl[i].rt] - b0, tbl[i].exp_wb);
      if (tbl[i].exp_wb != 0) begin
        chk("tbl_delay", wb_cyc[tbl[i].rt] - ins, tbl[i].exp_delay);
        chk("tbl_data", wb_dat[tbl[i].rt], dat_of(tbl[i].rt));
      end
    end

    // Single packet forwarded next cycle, written back once after 6 edges.
    b0 = wb_cnt[5]; da = {16{8'h11}};
    bus.q_addr_a = 7'd5; bus.in_pkt0 = mk(3'd2, 7'd5, da);
    tick(); ins = cyc; idle();
    chk("t1_hit", bus.fwd_hit[0], 1);
    chk("t1_data", bus.fwd_data_a, da);
    repeat (10) tick();
    chk("t1_wb_cnt", wb_cnt[5] - b0, 1);
    chk("t1_wb_edge", wb_cyc[5] - ins, 6);

    // Same rt from both pipes: younger wins the lookup.
    b0 = wb_cnt[9]; da = {4{32'hAAAA_0001}}; db = {4{32'hBBBB_0002}};
    bus.q_addr_b = 7'd9; bus.in_pkt0 = mk(3'd6, 7'd9, da); bus.in_pkt1 = mk(3'd2, 7'd9, db);
    tick(); ins = cyc; idle();
    chk("t2_young", {bus.fwd_hit[1], bus.fwd_data_b}, {1'b1, db});
    tick(); tick();
    chk("t2_old_wb", {bus.rf_we0, bus.rf_addr0, bus.rf_data0}, {1'b1, 7'd9, da});
    chk("t2_still_young", {bus.fwd_hit[1], bus.fwd_data_b}, {1'b1, db});
    repeat (10) tick();
    chk("t2_wb_cnt", wb_cnt[9] - b0, 2);
    chk("t2_last_wb", {wb_dat[9], 32'(wb_cyc[9] - ins)}, {db, 32'd6});

    // Flush drops the slot-3 packet, keeps the slot-5 one.
    b0 = wb_cnt[20]; b1 = wb_cnt[21]; be = elat_cnt + ecoll_cnt;
    bus.in_pkt0 = mk(3'd3, 7'd20, dat_of(7'd20)); bus.in_pkt1 = mk(3'd5, 7'd21, dat_of(7'd21));
    tick(); idle();
    bus.flush = 1'b1;
    tick(); ins = cyc; idle();
    repeat (10) tick();
    chk("t3_x_dropped", wb_cnt[20] - b0, 0);
    chk("t3_y_written", wb_cnt[21] - b1, 1);
    chk("t3_y_edge", wb_cyc[21] - ins, 2);
    chk("t3_no_err", elat_cnt + ecoll_cnt - be, 0);

    // Collision: later insert overwrites the shifted packet.
    b0 = wb_cnt[3]; b1 = wb_cnt[4];
    bus.in_pkt0 = mk(3'd2, 7'd3, dat_of(7'd3));
    tick();
    bus.in_pkt0 = mk(3'd3, 7'd4, dat_of(7'd4));
    tick(); idle();
    chk("t4_collision", bus.err_collision, 1);
    tick();
    chk("t4_pulse_end", bus.err_collision, 0);
    repeat (10) tick();
    chk("t4_rt3_lost", wb_cnt[3] - b0, 0);
    chk("t4_rt4_written", wb_cnt[4] - b1, 1);

    // Writeback conflict on equal rt.
    b0 = conf_cnt; b1 = wb_cnt[12];
    bus.in_pkt0 = mk(3'd4, 7'd12, dat_of(7'd12)); bus.in_pkt1 = mk(3'd4, 7'd12, ~dat_of(7'd12));
    tick(); ins = cyc; idle();
    repeat (10) tick();
    chk("t5_conf_cnt", conf_cnt - b0, 1);
    chk("t5_conf_edge", conf_cyc - ins, 4);
    chk("t5_conf_ports", {conf_we0, conf_addr0, conf_we1}, {1'b1, 7'd12, 1'b0});
    chk("t5_wb_cnt", wb_cnt[12] - b1, 1);

    // Bad latency, then asynchronous reset with packets in flight.
    b0 = wb_cnt[30];
    bus.in_pkt0 = mk(3'd0, 7'd30, dat_of(7'd30));
    tick(); idle();
    chk("t6_err_lat", bus.err_lat, 1);
    repeat (10) tick();
    chk("t6_no_wb", wb_cnt[30] - b0, 0);
    b2 = wb_cnt[40] + wb_cnt[41] + wb_cnt[42];
    bus.q_addr_a = 7'd40;
    bus.in_pkt0 = mk(3'd1, 7'd40, dat_of(7'd40)); tick();
    bus.in_pkt0 = mk(3'd1, 7'd41, dat_of(7'd41)); tick();
    bus.in_pkt0 = mk(3'd1, 7'd42, dat_of(7'd42)); tick(); idle();
    chk("t6_inflight_hit", bus.fwd_hit[0], 1);
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_outs", {bus.rf_we0, bus.rf_we1, bus.fwd_hit, bus.err_lat, bus.err_collision, bus.wb_conflict}, 0);
    chk("t6_rst_data", bus.fwd_data_a, 0);
    #1 reset = 1'b1;
    repeat (12) tick();
    chk("t6_nothing_written", wb_cnt[40] + wb_cnt[41] + wb_cnt[42] - b2, 0);

    // Randomized run against the aged-list model.
    reset = 1'b0; #1 reset = 1'b1;
    mq.delete();
    for (int c = 0; c < 500; c++) begin
      p0 = {7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            $urandom, $urandom, $urandom, $urandom};
      p1 = {7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            $urandom, $urandom, $urandom, $urandom};
      fl = ($urandom_range(0, 15) == 0);
      bus.in_pkt0 = p0; bus.in_pkt1 = p1; bus.flush = fl;
      bus.q_addr_a = 7'($urandom_range(0, 7));
      bus.q_addr_b = 7'($urandom_range(0, 7));
      bus.q_addr_c = 7'($urandom_range(0, 7));
      #1;
      chk("rnd_fwd_a", {bus.fwd_hit[0], bus.fwd_data_a}, model_fwd(bus.q_addr_a));
      chk("rnd_fwd_b", {bus.fwd_hit[1], bus.fwd_data_b}, model_fwd(bus.q_addr_b));
      chk("rnd_fwd_c", {bus.fwd_hit[2], bus.fwd_data_c}, model_fwd(bus.q_addr_c));
      tick();
      model_step(p0, p1, fl, el, ec);
      w0 = 1'b0; w1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
      foreach (mq[i]) begin
        if (mq[i].age == DEPTH + 1) begin
          if (mq[i].p) begin w1 = 1'b1; a1 = mq[i].rt; d1 = mq[i].d; end
          else         begin w0 = 1'b1; a0 = mq[i].rt; d0 = mq[i].d; end
        end
      end
      cf = w0 && w1 && (a0 == a1);
      if (cf) begin w1 = 1'b0; a1 = '0; d1 = '0; end
      chk("rnd_rf0", {bus.rf_we0, bus.rf_we0 ? bus.rf_addr0 : 7'd0, bus.rf_we0 ? bus.rf_data0 : 128'd0},
          {w0, a0, d0});
      chk("rnd_rf1", {bus.rf_we1, bus.rf_we1 ? bus.rf_addr1 : 7'd0, bus.rf_we1 ? bus.rf_data1 : 128'd0},
          {w1, a1, d1});
      chk("rnd_flags", {bus.err_lat, bus.err_collision, bus.wb_conflict}, {el, ec, cf});
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
